imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
//  Sequences in-system program loading of instruction memory from UART rx bytes.
//  Packs the little-endian byte stream into 32-bit words and writes them from word 0 upward.
//  Holds the CPU in reset while loading, detects end of image by line-idle timeout, then releases the CPU.
//  Sits between uart_rx and the imem write port; replaces ad-hoc byte-lane writes inside imem.
// PARAMETERS
//  ADDR_W        10         byte address width; image capacity 2**ADDR_W bytes (default 1 KiB = 256 words)
//  IDLE_TIMEOUT  2_700_000  idle clk cycles after last byte that end a load (0.1 s at 27 MHz); >=2
//  HOLD_CYCLES   16         clk cycles cpu_rst stays high after a good load; >=1
// PORTS
//  clk        in   1         system clock
//  reset      in   1         asynchronous, active-high reset
//  rx_valid   in   1         one-cycle strobe: rx_data holds a received byte
//  rx_data    in   8         received byte
//  mem_we     out  1         one-cycle imem word write strobe
//  mem_waddr  out  ADDR_W-2  imem word address
//  mem_wdata  out  32        word data; byte k of the stream -> bits [8*(k%4)+7 : 8*(k%4)]
//  cpu_rst    out  1         1 = hold CPU/PC in reset
//  load_busy  out  1         1 while state != IDLE
//  load_done  out  1         one-cycle pulse when the CPU is released after a good load
//  load_err   out  1         sticky; cleared when the next load starts
//  byte_cnt   out  ADDR_W+1  bytes accepted in the current/last load (saturates at 2**ADDR_W)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; word buffer, lane index, timer, counters cleared.
//  States: IDLE -> RECV -> FLUSH -> CHECK -> HOLD -> IDLE; ERR is terminal until next byte.
//  IDLE: cpu_rst=0. rx_valid -> RECV; the byte is lane 0 of word 0; byte_cnt=1; load_err cleared.
//  RECV: cpu_rst=1. Each rx_valid stores byte in lane byte_cnt[1:0], byte_cnt++, idle timer reloads.
//   On the 4th lane: mem_we=1 next cycle with mem_waddr=byte_cnt_old[ADDR_W-1:2]; latency 1 cycle.
//   Byte while byte_cnt==2**ADDR_W: dropped, no write, overflow flag set (-> ERR at CHECK).
//   Idle timer hits IDLE_TIMEOUT-1 with no rx_valid -> FLUSH. rx_valid in the same cycle wins (reload).
//  FLUSH (1 cycle): if byte_cnt[1:0]!=0, write partial word, unfilled upper lanes = 8'h00; else no write.
//  CHECK (1 cycle): overflow or checksum failure -> ERR (load_err=1), else HOLD.
//  HOLD: cpu_rst=1 for HOLD_CYCLES cycles, then IDLE with load_done pulse (cpu_rst falls same cycle).
//  ERR: cpu_rst=1, load_err=1; rx_valid -> RECV as from IDLE (new load from word 0).
//  rx_valid during FLUSH/CHECK: byte dropped, load_err=1 at CHECK exit. During HOLD: abort hold, new load.
//  Async reset mid-load: immediate return to IDLE, cpu_rst=0; partial image stays in imem.
//  mem_we never asserted outside RECV/FLUSH; at most one write per cycle.
// CONFIGURATION
//  IMEM_LOAD_CHECKSUM_EN defined: the last byte of the image is a checksum; the 8-bit mod-256 sum
//   of all accepted bytes (checksum included) must be 8'h00, else CHECK -> ERR. The checksum byte is
//   written to imem like any other byte.
//  Undefined: no checksum logic; CHECK fails only on overflow/dropped byte.
// STRUCTURE
//  Package imem_load_pkg: state enum (IDLE,RECV,FLUSH,CHECK,HOLD,ERR), LANES=4, BYTE_W=8.
//  Sub-module idle_timer (load, enable, expire; width $clog2(IDLE_TIMEOUT)); also reused for the HOLD count.
// TESTING (IDLE_TIMEOUT=100, HOLD_CYCLES=4, ADDR_W=4, bytes spaced 20 cycles)
//  Send 8'h13,8'h05,8'h00,8'h00 -> one mem_we, addr 0, data 32'h00000513; cpu_rst=1 from 1st byte; after timeout+HOLD, load_done pulse, cpu_rst=0.
//  Send 6 bytes 01..06 -> writes addr0=32'h04030201, then FLUSH addr1=32'h00000605; byte_cnt=6.
//  Send 17 bytes (capacity 16) -> 4 writes only, load_err=1, cpu_rst stays 1; next byte clears load_err, restarts at addr 0.
//  rx_valid exactly on timer terminal cycle -> stays RECV, timer reloads, no FLUSH.
//  Assert reset mid-RECV after 2 bytes -> all outputs 0 next edge, no write; following byte starts at addr 0.
//  CHECKSUM_EN: bytes 01,02,03,FA -> HOLD and load_done; bytes 01,02,03,FB -> ERR, load_err=1.

Source files
------------

// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and constants for the UART-driven instruction memory loader.
// The state encoding and byte-lane geometry live here so the timer, top and bench agree.
package imem_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        FLUSH,
        CHECK,
        HOLD,
        ERR
    } state_t;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Bundle of the rx byte stream, imem write port and loader status signals.
// The controller uses the slave view; whatever feeds bytes and watches status uses master.
interface imem_load_ctrl_if #(
    parameter int ADDR_W = 10
);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   byte_cnt;

    modport master (
        output rx_valid, rx_data,
        input  mem_we, mem_waddr, mem_wdata, cpu_rst,
        input  load_busy, load_done, load_err, byte_cnt
    );

    modport slave (
        input  rx_valid, rx_data,
        output mem_we, mem_waddr, mem_wdata, cpu_rst,
        output load_busy, load_done, load_err, byte_cnt
    );

endinterface

// File: rtl/imem_load_ctrl_idle_timer.sv
// Up-counter that raises expire when it reaches a caller-chosen terminal value.
// Shared between the line-idle timeout and the post-load CPU hold interval.
module idle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;

    assign expire_o = (cnt_q == term_i);

    // Parks at the terminal value so a late consumer still sees expire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expire_o) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Packs UART bytes little-endian into imem words, holds the CPU in reset while loading.
// Optional IMEM_LOAD_CHECKSUM_EN: image must sum to 8'h00 mod 256 or the load ends in ERR.
module imem_load_ctrl
    import imem_load_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int IDLE_TIMEOUT = 2_700_000,
    parameter int HOLD_CYCLES  = 16
) (
    input  logic            clk,
    input  logic            reset,
    imem_load_ctrl_if.slave bus
);

    localparam int TW_IDLE = $clog2(IDLE_TIMEOUT);
    localparam int TW_HOLD = $clog2(HOLD_CYCLES);
    localparam int TW      = (TW_IDLE > TW_HOLD) ? TW_IDLE : TW_HOLD;
    localparam int CW      = ADDR_W + 1;
    localparam logic [TW-1:0] IDLE_TERM = TW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0] HOLD_TERM = TW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CAP       = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [31:0]       wordBuf_q, wordBuf_d;
    logic [CW-1:0]     byteCnt_q, byteCnt_d;
    logic              ovf_q, ovf_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-3:0] memWaddr_q, memWaddr_d;
    logic [31:0]       memWdata_q, memWdata_d;
    logic              loadDone_q, loadDone_d;
    logic              loadErr_q, loadErr_d;

    logic              timerLoad, timerExpire;
    logic              startLoad, acceptByte, csumBad;
    logic [1:0]        lane;

    idle_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timerLoad),
        .enable_i ((state_q == RECV) || (state_q == HOLD)),
        .term_i   ((state_q == HOLD) ? HOLD_TERM : IDLE_TERM),
        .expire_o (timerExpire)
    );

    assign lane = byteCnt_q[1:0];

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (startLoad) begin
            sum_d = bus.rx_data;
        end else if (acceptByte) begin
            sum_d = sum_q + bus.rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign csumBad = (sum_q != 8'h00);
`else
    assign csumBad = 1'b0;
`endif

    // A byte arriving in IDLE, HOLD or ERR always restarts the image at word 0.
    always_comb begin
        state_d    = state_q;
        wordBuf_d  = wordBuf_q;
        byteCnt_d  = byteCnt_q;
        ovf_d      = ovf_q;
        memWe_d    = 1'b0;
        memWaddr_d = memWaddr_q;
        memWdata_d = memWdata_q;
        loadDone_d = 1'b0;
        loadErr_d  = loadErr_q;
        timerLoad  = 1'b0;
        startLoad  = 1'b0;
        acceptByte = 1'b0;

        case (state_q)
            IDLE, ERR: begin
                if (bus.rx_valid) startLoad = 1'b1;
            end
            HOLD: begin
                if (bus.rx_valid) begin
                    startLoad = 1'b1;
                end else if (timerExpire) begin
                    state_d    = IDLE;
                    loadDone_d = 1'b1;
                end
            end
            RECV: begin
                if (bus.rx_valid) begin
                    timerLoad = 1'b1;
                    if (byteCnt_q == CAP) ovf_d = 1'b1;
                    else                  acceptByte = 1'b1;
                end else if (timerExpire) begin
                    state_d = FLUSH;
                    if (lane != 2'd0) begin
                        memWe_d    = 1'b1;
                        memWaddr_d = byteCnt_q[ADDR_W-1:2];
                        memWdata_d = wordBuf_q;
                    end
                end
            end
            FLUSH: begin
                state_d = CHECK;
                if (bus.rx_valid) ovf_d = 1'b1;
            end
            CHECK: begin
                if (ovf_q || bus.rx_valid || csumBad) begin
                    state_d   = ERR;
                    loadErr_d = 1'b1;
                end else begin
                    state_d   = HOLD;
                    timerLoad = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (startLoad) begin
            state_d   = RECV;
            timerLoad = 1'b1;
            wordBuf_d = {24'h0, bus.rx_data};
            byteCnt_d = CW'(1);
            ovf_d     = 1'b0;
            loadErr_d = 1'b0;
        end

        // Upper lanes are cleared after each full word so a FLUSH write is zero-padded.
        if (acceptByte) begin
            byteCnt_d = byteCnt_q + CW'(1);
            if (lane == 2'(LANES - 1)) begin
                memWe_d    = 1'b1;
                memWaddr_d = byteCnt_q[ADDR_W-1:2];
                memWdata_d = {bus.rx_data, wordBuf_q[23:0]};
                wordBuf_d  = '0;
            end else begin
                wordBuf_d[BYTE_W*lane +: BYTE_W] = bus.rx_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wordBuf_q  <= '0;
            byteCnt_q  <= '0;
            ovf_q      <= 1'b0;
            memWe_q    <= 1'b0;
            memWaddr_q <= '0;
            memWdata_q <= '0;
            loadDone_q <= 1'b0;
            loadErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wordBuf_q  <= wordBuf_d;
            byteCnt_q  <= byteCnt_d;
            ovf_q      <= ovf_d;
            memWe_q    <= memWe_d;
            memWaddr_q <= memWaddr_d;
            memWdata_q <= memWdata_d;
            loadDone_q <= loadDone_d;
            loadErr_q  <= loadErr_d;
        end
    end

    assign bus.mem_we    = memWe_q;
    assign bus.mem_waddr = memWaddr_q;
    assign bus.mem_wdata = memWdata_q;
    assign bus.cpu_rst   = (state_q != IDLE);
    assign bus.load_busy = (state_q != IDLE);
    assign bus.load_done = loadDone_q;
    assign bus.load_err  = loadErr_q;
    assign bus.byte_cnt  = byteCnt_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: small image (16 bytes), short idle timeout and hold.
// Inputs change on the falling edge; every observation is also taken on the falling edge.
module tb_imem_load_ctrl;

    localparam int ADDR_W       = 4;
    localparam int IDLE_TIMEOUT = 100;
    localparam int HOLD_CYCLES  = 4;
`ifdef IMEM_LOAD_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   wrAddrQ[$];
    logic [31:0] wrDataQ[$];

    imem_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    imem_load_ctrl #(
        .ADDR_W       (ADDR_W),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .HOLD_CYCLES  (HOLD_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every imem write so tests can inspect address/data order afterwards.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wrAddrQ.push_back(int'(bus.mem_waddr));
            wrDataQ.push_back(bus.mem_wdata);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic clearLog();
        wrAddrQ.delete();
        wrDataQ.delete();
    endtask

    // Waits until the load either finishes or ends in error; a timeout counts as a failure.
    task automatic waitSettle(input string name, input int budget);
        int n;
        n = 0;
        while ((bus.load_busy === 1'b1) && (bus.load_err !== 1'b1) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("[TB] FAIL %s settle: still busy after %0d cycles, required settle within %0d", name, n, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(3);
        checks++;
        if ({bus.mem_we, bus.cpu_rst, bus.load_busy, bus.load_done, bus.load_err} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=00000", {bus.mem_we, bus.cpu_rst, bus.load_busy, bus.load_done, bus.load_err});
        end
        checks++;
        if (bus.byte_cnt !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_byte_cnt got=%0d exp=0", bus.byte_cnt);
        end
        checks++;
        if ((bus.mem_waddr !== 2'd0) || (bus.mem_wdata !== 32'h0)) begin
            failures++;
            $display("[TB] FAIL reset_wport got=%h/%h exp=0/00000000", bus.mem_waddr, bus.mem_wdata);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_single_word();
        logic [7:0] img[4];
        img = '{8'h13, 8'h05, 8'h00, 8'h00};
        clearLog();
        for (int i = 0; i < 4; i++) begin
            sendByte(img[i]);
            if (i == 0) begin
                checks++;
                if (bus.cpu_rst !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL single_cpu_rst_first got=%b exp=1", bus.cpu_rst);
                end
            end
            if (i < 3) idle(19);
        end
        waitSettle("single", 400);
        checks++;
        if ((wrAddrQ.size() != 1) || (wrAddrQ[0] != 0) || (wrDataQ[0] !== 32'h00000513)) begin
            failures++;
            $display("[TB] FAIL single_write got n=%0d a=%0d d=%h exp n=1 a=0 d=00000513",
                     wrAddrQ.size(), (wrAddrQ.size() > 0) ? wrAddrQ[0] : -1, (wrDataQ.size() > 0) ? wrDataQ[0] : 32'hx);
        end
        checks++;
        if ({bus.load_done, bus.cpu_rst, bus.load_err} !== {!CSUM, CSUM, CSUM}) begin
            failures++;
            $display("[TB] FAIL single_release done/rst/err got=%b exp=%b", {bus.load_done, bus.cpu_rst, bus.load_err}, {!CSUM, CSUM, CSUM});
        end
        checks++;
        if (bus.byte_cnt !== 5'd4) begin
            failures++;
            $display("[TB] FAIL single_byte_cnt got=%0d exp=4", bus.byte_cnt);
        end
        idle(2);
        checks++;
        if (bus.load_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_done_pulse got=%b exp=0", bus.load_done);
        end
    endtask

    task automatic test_partial_flush();
        clearLog();
        for (int i = 1; i <= 6; i++) begin
            sendByte(8'(i));
            if (i < 6) idle(19);
        end
        waitSettle("partial", 400);
        checks++;
        if (wrAddrQ.size() != 2) begin
            failures++;
            $display("[TB] FAIL partial_nwrites got=%0d exp=2", wrAddrQ.size());
        end else begin
            checks++;
            if ((wrAddrQ[0] != 0) || (wrDataQ[0] !== 32'h04030201)) begin
                failures++;
                $display("[TB] FAIL partial_word0 got a=%0d d=%h exp a=0 d=04030201", wrAddrQ[0], wrDataQ[0]);
            end
            checks++;
            if ((wrAddrQ[1] != 1) || (wrDataQ[1] !== 32'h00000605)) begin
                failures++;
                $display("[TB] FAIL partial_flush got a=%0d d=%h exp a=1 d=00000605", wrAddrQ[1], wrDataQ[1]);
            end
        end
        checks++;
        if (bus.byte_cnt !== 5'd6) begin
            failures++;
            $display("[TB] FAIL partial_byte_cnt got=%0d exp=6", bus.byte_cnt);
        end
        idle(2);
    endtask

    task automatic test_overflow();
        clearLog();
        for (int i = 1; i <= 17; i++) begin
            sendByte(8'(i));
            if (i < 17) idle(19);
        end
        waitSettle("overflow", 400);
        checks++;
        if ((wrAddrQ.size() != 4) || (wrAddrQ[3] != 3) || (wrDataQ[3] !== 32'h100F0E0D)) begin
            failures++;
            $display("[TB] FAIL overflow_writes got n=%0d exp n=4 last a=3 d=100f0e0d", wrAddrQ.size());
        end
        checks++;
        if ({bus.load_err, bus.cpu_rst, bus.load_busy, bus.load_done} !== 4'b1110) begin
            failures++;
            $display("[TB] FAIL overflow_err err/rst/busy/done got=%b exp=1110", {bus.load_err, bus.cpu_rst, bus.load_busy, bus.load_done});
        end
        checks++;
        if (bus.byte_cnt !== 5'd16) begin
            failures++;
            $display("[TB] FAIL overflow_byte_cnt got=%0d exp=16", bus.byte_cnt);
        end
        idle(10);
        clearLog();
        sendByte(8'hAA);
        checks++;
        if ({bus.load_err, bus.cpu_rst} !== 2'b01 || bus.byte_cnt !== 5'd1) begin
            failures++;
            $display("[TB] FAIL overflow_restart err/rst got=%b cnt=%0d exp=01 cnt=1", {bus.load_err, bus.cpu_rst}, bus.byte_cnt);
        end
        idle(19); sendByte(8'hBB);
        idle(19); sendByte(8'hCC);
        idle(19); sendByte(8'hDD);
        idle(2);
        checks++;
        if ((wrAddrQ.size() != 1) || (wrAddrQ[0] != 0) || (wrDataQ[0] !== 32'hDDCCBBAA)) begin
            failures++;
            $display("[TB] FAIL overflow_reload_word got n=%0d exp n=1 a=0 d=ddccbbaa", wrAddrQ.size());
        end
        waitSettle("overflow_reload", 400);
        idle(2);
    endtask

    task automatic test_timer_terminal();
        clearLog();
        sendByte(8'h01);
        idle(IDLE_TIMEOUT - 1);
        sendByte(8'h02);
        checks++;
        if ((bus.byte_cnt !== 5'd2) || (bus.load_busy !== 1'b1) || (wrAddrQ.size() != 0)) begin
            failures++;
            $display("[TB] FAIL terminal_reload got cnt=%0d busy=%b nwr=%0d exp cnt=2 busy=1 nwr=0",
                     bus.byte_cnt, bus.load_busy, wrAddrQ.size());
        end
        idle(19); sendByte(8'h03);
        idle(19); sendByte(8'h04);
        idle(2);
        checks++;
        if ((wrAddrQ.size() != 1) || (wrAddrQ[0] != 0) || (wrDataQ[0] !== 32'h04030201)) begin
            failures++;
            $display("[TB] FAIL terminal_word got n=%0d exp n=1 a=0 d=04030201", wrAddrQ.size());
        end
        waitSettle("terminal", 400);
        idle(2);
    endtask

    task automatic test_reset_mid_load();
        clearLog();
        sendByte(8'hA1);
        idle(19);
        sendByte(8'hA2);
        idle(5);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.mem_we, bus.cpu_rst, bus.load_busy, bus.load_done, bus.load_err} !== 5'b0 || bus.byte_cnt !== 5'd0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got=%b cnt=%0d exp=00000 cnt=0",
                     {bus.mem_we, bus.cpu_rst, bus.load_busy, bus.load_done, bus.load_err}, bus.byte_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        checks++;
        if (wrAddrQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL midreset_nowrite got=%0d exp=0", wrAddrQ.size());
        end
        sendByte(8'h11); idle(19);
        sendByte(8'h22); idle(19);
        sendByte(8'h33); idle(19);
        sendByte(8'h44);
        idle(2);
        checks++;
        if ((wrAddrQ.size() != 1) || (wrAddrQ[0] != 0) || (wrDataQ[0] !== 32'h44332211)) begin
            failures++;
            $display("[TB] FAIL midreset_restart got n=%0d exp n=1 a=0 d=44332211", wrAddrQ.size());
        end
        waitSettle("midreset", 400);
        idle(2);
    endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] good[4];
        logic [7:0] bad[4];
        good = '{8'h01, 8'h02, 8'h03, 8'hFA};
        bad  = '{8'h01, 8'h02, 8'h03, 8'hFB};
        for (int i = 0; i < 4; i++) begin
            sendByte(good[i]);
            if (i < 3) idle(19);
        end
        waitSettle("csum_good", 400);
        checks++;
        if ({bus.load_done, bus.load_err, bus.cpu_rst} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL csum_good done/err/rst got=%b exp=100", {bus.load_done, bus.load_err, bus.cpu_rst});
        end
        idle(2);
        for (int i = 0; i < 4; i++) begin
            sendByte(bad[i]);
            if (i < 3) idle(19);
        end
        waitSettle("csum_bad", 400);
        checks++;
        if ({bus.load_done, bus.load_err, bus.cpu_rst} !== 3'b011) begin
            failures++;
            $display("[TB] FAIL csum_bad done/err/rst got=%b exp=011", {bus.load_done, bus.load_err, bus.cpu_rst});
        end
        idle(2);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_partial_flush();
        test_overflow();
        test_timer_terminal();
        test_reset_mid_load();
`ifdef IMEM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
